// File: rtl/cmn_age_matrix_if.sv
// Allocation / age-matrix bundle between the age tracker and its users.
// The master side requests allocations and frees; the slave side is the tracker.
interface cmn_age_matrix_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             alloc_vld;
  logic             alloc_rdy;
  logic [WIDTH-1:0] alloc_onehot;
  logic [WIDTH-1:0] v_dealloc;
  logic [WIDTH-1:0] vv_matrix [WIDTH-1:0];
  logic [WIDTH-1:0] v_occupied;
  logic [WIDTH-1:0] oldest_onehot;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  modport master (
    output alloc_vld, v_dealloc,
    input  alloc_rdy, alloc_onehot, vv_matrix, v_occupied, oldest_onehot,
           count, full, empty
  );

  modport slave (
    input  alloc_vld, v_dealloc,
    output alloc_rdy, alloc_onehot, vv_matrix, v_occupied, oldest_onehot,
           count, full, empty
  );
endinterface

// File: rtl/cmn_age_matrix.sv
// Age tracker producing the priority matrix for a matrix arbiter (oldest wins).
// Optional macro CMN_AGE_MATRIX_DEALLOC_BYPASS_EN lets same-cycle frees be reallocated.
module cmn_age_matrix #(
  parameter int WIDTH = 4
) (
  input logic             clk,
  input logic             rst,
  cmn_age_matrix_if.slave aif
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] occ_p0;
  logic [WIDTH-1:0] mat_p0  [WIDTH-1:0];
  logic [WIDTH-1:0] mat_nxt [WIDTH-1:0];
  logic [WIDTH-1:0] occ_nxt;
  logic [WIDTH-1:0] free_v;
  logic [WIDTH-1:0] alloc_oh;
  logic [WIDTH-1:0] dealloc_eff;
  logic [CNT_W-1:0] cnt;
  logic             fire;

  function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  always_comb begin
`ifdef CMN_AGE_MATRIX_DEALLOC_BYPASS_EN
    free_v = ~(occ_p0 & ~aif.v_dealloc);
`else
    free_v = ~occ_p0;
`endif
    // Two's-complement trick isolates the lowest set bit; zero when nothing is free.
    alloc_oh = free_v & (-free_v);
  end

  assign aif.alloc_rdy    = |free_v;
  assign aif.alloc_onehot = alloc_oh;
  assign fire             = aif.alloc_vld & aif.alloc_rdy;
  assign dealloc_eff      = aif.v_dealloc & occ_p0;

  always_comb begin
    occ_nxt = occ_p0 & ~dealloc_eff;
    if (fire) occ_nxt = occ_nxt | alloc_oh;
    for (int i = 0; i < WIDTH; i++) begin
      mat_nxt[i] = dealloc_eff[i] ? '0 : (mat_p0[i] & ~dealloc_eff);
      if (fire) mat_nxt[i] = mat_nxt[i] & ~alloc_oh;
      // The new entry is younger than every entry that survives this cycle.
      if (fire && alloc_oh[i]) mat_nxt[i] = occ_p0 & ~aif.v_dealloc & ~alloc_oh;
    end
  end

  // Stage p0: occupancy and pairwise age state.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_p0 <= '0;
      for (int i = 0; i < WIDTH; i++) mat_p0[i] <= '0;
    end else begin
      occ_p0 <= occ_nxt;
      for (int i = 0; i < WIDTH; i++) mat_p0[i] <= mat_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      aif.vv_matrix[i]     = mat_p0[i];
      aif.oldest_onehot[i] = occ_p0[i] & ~|(mat_p0[i] & occ_p0);
    end
  end

  assign cnt            = popcnt(occ_p0);
  assign aif.count      = cnt;
  assign aif.v_occupied = occ_p0;
  assign aif.full       = (cnt == CNT_W'(WIDTH));
  assign aif.empty      = (cnt == '0);
endmodule

// File: tb/tb_cmn_age_matrix.sv
// Scoreboard bench for cmn_age_matrix: directed scenarios plus random traffic
// compared against an ordered-list age model.
module tb_cmn_age_matrix;
  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);
`ifdef CMN_AGE_MATRIX_DEALLOC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0]         occ;
    logic [CW-1:0]        cnt;
    logic                 full;
    logic                 empty;
    logic                 rdy;
    logic [W-1:0]         oh;
    logic [W-1:0]         oldest;
    logic [W-1:0][W-1:0]  mat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmn_age_matrix_if #(.WIDTH(W)) aif ();

  cmn_age_matrix #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .aif (aif)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb [$];
  int   q  [$];   // model: slot ids, oldest first

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, idx, act, req, $time);
  endtask

  function automatic logic [W-1:0] busy_mask();
    logic [W-1:0] m = '0;
    foreach (q[k]) m[q[k]] = 1'b1;
    return m;
  endfunction

  task automatic model_alloc(input logic [W-1:0] dl, output logic rdy, output logic [W-1:0] oh);
    logic [W-1:0] b;
    logic found = 1'b0;
    b = busy_mask();
    if (BYPASS) b = b & ~dl;
    oh = '0;
    for (int i = 0; i < W; i++)
      if (!b[i] && !found) begin oh[i] = 1'b1; found = 1'b1; end
    rdy = found;
  endtask

  task automatic model_expect(input logic [W-1:0] dl, output exp_t e);
    e = '0;
    e.occ   = busy_mask();
    e.cnt   = CW'(q.size());
    e.full  = (q.size() == W);
    e.empty = (q.size() == 0);
    model_alloc(dl, e.rdy, e.oh);
    if (q.size() > 0) e.oldest[q[0]] = 1'b1;
    for (int a = 0; a < q.size(); a++)
      for (int b = 0; b < a; b++) e.mat[q[a]][q[b]] = 1'b1;
  endtask

  task automatic model_step(input logic vld, input logic [W-1:0] dl, input logic r);
    logic rdy;
    logic [W-1:0] oh;
    int keep [$];
    if (r) begin q.delete(); return; end
    model_alloc(dl, rdy, oh);
    foreach (q[k]) if (!dl[q[k]]) keep.push_back(q[k]);
    q = keep;
    if (vld && rdy)
      for (int i = 0; i < W; i++) if (oh[i]) q.push_back(i);
  endtask

  // One cycle of stimulus: expectations for this cycle's view go to the scoreboard.
  task automatic cyc(input logic vld, input logic [W-1:0] dl, input logic r);
    exp_t e;
    @(posedge clk);
    #1;
    model_expect(dl, e);
    sb.push_back(e);
    aif.alloc_vld = vld;
    aif.v_dealloc = dl;
    rst           = r;
    model_step(vld, dl, r);
  endtask

  // Monitor: compares every presented cycle against the scoreboard, plus structural invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("v_occupied", 0, 32'(aif.v_occupied), 32'(e.occ));
        chk("count", 0, 32'(aif.count), 32'(e.cnt));
        chk("full", 0, 32'(aif.full), 32'(e.full));
        chk("empty", 0, 32'(aif.empty), 32'(e.empty));
        chk("alloc_rdy", 0, 32'(aif.alloc_rdy), 32'(e.rdy));
        chk("alloc_onehot", 0, 32'(aif.alloc_onehot), 32'(e.oh));
        chk("oldest_onehot", 0, 32'(aif.oldest_onehot), 32'(e.oldest));
        for (int i = 0; i < W; i++) begin
          chk("vv_matrix", i, 32'(aif.vv_matrix[i]), 32'(e.mat[i]));
          chk("diag", i, 32'(aif.vv_matrix[i][i]), 32'd0);
          for (int j = i + 1; j < W; j++)
            if (e.occ[i] && e.occ[j])
              chk("antisym", i * W + j, 32'(aif.vv_matrix[i][j] ^ aif.vv_matrix[j][i]), 32'd1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    aif.alloc_vld = 1'b0;
    aif.v_dealloc = '0;
    cyc(0, 4'b0000, 1);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("rst_count", 0, 32'(aif.count), 32'd0);
    chk("rst_onehot", 0, 32'(aif.alloc_onehot), 32'b0001);
    chk("rst_empty", 0, 32'(aif.empty), 32'd1);

    for (int k = 0; k < 4; k++) cyc(1, 4'b0000, 0);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("fill_full", 0, 32'(aif.full), 32'd1);
    chk("fill_rdy", 0, 32'(aif.alloc_rdy), 32'd0);
    chk("fill_oldest", 0, 32'(aif.oldest_onehot), 32'b0001);
    chk("fill_row3", 0, 32'(aif.vv_matrix[3]), 32'b0111);
    chk("fill_row0", 0, 32'(aif.vv_matrix[0]), 32'b0000);

    cyc(0, 4'b0001, 0);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("free0_oldest", 0, 32'(aif.oldest_onehot), 32'b0010);
    chk("free0_count", 0, 32'(aif.count), 32'd3);
    chk("free0_row3", 0, 32'(aif.vv_matrix[3]), 32'b0110);

    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("realloc_row0", 0, 32'(aif.vv_matrix[0]), 32'b1110);

    cyc(1, 4'b0100, 0);
    @(negedge clk);
    chk("bypass_rdy", 0, 32'(aif.alloc_rdy), BYPASS ? 32'd1 : 32'd0);
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("swap_count", 0, 32'(aif.count), 32'd4);
    chk("swap_row2", 0, 32'(aif.vv_matrix[2]), 32'b1011);

    cyc(1, 4'b0000, 1);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("rstfull_occ", 0, 32'(aif.v_occupied), 32'd0);
    chk("rstfull_oh", 0, 32'(aif.alloc_onehot), 32'b0001);

    cyc(1, 4'b0000, 0);
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b1010, 0);
    cyc(0, 4'b0000, 0);
    @(negedge clk);
    chk("partial_occ", 0, 32'(aif.v_occupied), 32'b0001);
    chk("partial_count", 0, 32'(aif.count), 32'd1);

    for (int n = 0; n < 10000; n++) begin
      logic [W-1:0] dl;
      for (int b = 0; b < W; b++) dl[b] = ($urandom_range(0, 99) < 20);
      cyc(($urandom_range(0, 99) < 60), dl, ($urandom_range(0, 999) == 0));
    end
    cyc(0, 4'b0000, 0);

    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) chk("drain", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
